// File: rtl/fetch_request_unit_pkg.sv
// rtl/fetch_request_unit_pkg.sv - shared types and configuration for the fetch request unit
package fetch_request_unit_pkg;

  localparam int XLEN = 32;
  localparam int FETCH_BUFFER_DEPTH = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instruction;
  } instruction_buffer_packet;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_request_unit_if.sv
// rtl/fetch_request_unit_if.sv - instruction memory and instruction buffer signals of the fetch unit
interface fetch_request_unit_if
  import fetch_request_unit_pkg::*;
();

  logic                     mem_req;
  logic [XLEN-1:0]          mem_addr;
  logic                     mem_ack;
  logic                     mem_rvalid;
  logic [31:0]              mem_rdata;
  logic                     ib_push;
  instruction_buffer_packet ib_data_in;
  logic                     ib_flush;
  logic                     ib_pop;

  modport master (
    output mem_req, mem_addr, ib_push, ib_data_in, ib_flush,
    input  mem_ack, mem_rvalid, mem_rdata, ib_pop
  );

  modport slave (
    input  mem_req, mem_addr, ib_push, ib_data_in, ib_flush,
    output mem_ack, mem_rvalid, mem_rdata, ib_pop
  );

endinterface

// File: rtl/fetch_request_unit_pc_fifo.sv
// rtl/fetch_request_unit_pc_fifo.sv - circular FIFO of issued fetch PCs, aligned with memory responses
module fetch_pc_fifo
  import fetch_request_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic            pop,
  output logic [XLEN-1:0] head_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [XLEN-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  // Occupancy is never tracked here: the owner never pushes when full or pops when empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_pc;
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign head_pc = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_request_unit.sv
// rtl/fetch_request_unit.sv - fetch PC owner issuing word requests and pushing returned words to the IB
module fetch_request_unit
  import fetch_request_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  input  logic                 redirect,
  input  logic [XLEN-1:0]      redirect_pc,
  fetch_request_unit_if.master bus
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int RES_W = $clog2(FETCH_BUFFER_DEPTH) + 1;
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
  localparam logic [RES_W-1:0] RES_MAX = RES_W'(FETCH_BUFFER_DEPTH);

  fetch_state_t     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] discard_q, discard_d;
  logic [RES_W-1:0] reserved_q, reserved_d;
  logic             req;
  logic             issue;
  logic             resp;
  logic             drop;
  logic             live_pop;
  logic [XLEN-1:0]  head_pc;

  fetch_pc_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (issue),
    .push_pc (pc_q),
    .pop     (resp),
    .head_pc (head_pc)
  );

  always_comb begin
    state_d = fetch_en ? FETCH : IDLE;

    req      = (state_q == FETCH) && !redirect &&
               (outstanding_q < OUT_MAX) && (reserved_q < RES_MAX);
    issue    = req && bus.mem_ack;
    resp     = bus.mem_rvalid && (outstanding_q != '0);
    drop     = resp && ((discard_q != '0) || redirect);
    // A pop can only return a credit held by a live buffer entry.
    live_pop = bus.ib_pop && (reserved_q > RES_W'(outstanding_q));

    outstanding_d = outstanding_q;
    if (issue) outstanding_d = outstanding_d + OUT_W'(1);
    if (resp)  outstanding_d = outstanding_d - OUT_W'(1);

    pc_d = pc_q;
    if (redirect) begin
      pc_d = word_align(redirect_pc);
    end else if (issue) begin
      pc_d = pc_q + XLEN'(4);
    end

    discard_d  = discard_q;
    reserved_d = reserved_q;
    if (redirect) begin
      // Everything still in flight is stale and the buffer is flushed, so credits collapse too.
      discard_d  = outstanding_d;
      reserved_d = RES_W'(outstanding_d);
    end else begin
      if (drop && (discard_q != '0)) discard_d = discard_q - OUT_W'(1);
      if (issue)    reserved_d = reserved_d + RES_W'(1);
      if (drop)     reserved_d = reserved_d - RES_W'(1);
      if (live_pop) reserved_d = reserved_d - RES_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      reserved_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      reserved_q    <= reserved_d;
    end
  end

  assign bus.mem_req    = req;
  assign bus.mem_addr   = pc_q;
  assign bus.ib_push    = resp && !drop;
  assign bus.ib_data_in = '{pc: head_pc, instruction: bus.mem_rdata};
  assign bus.ib_flush   = redirect;

  // Returned data with nothing in flight is a memory-side protocol error; the logic ignores it.
  assert property (@(posedge clk) disable iff (rst) !(bus.mem_rvalid && (outstanding_q == '0)));

endmodule

// File: tb/tb_fetch_request_unit.sv
// tb/tb_fetch_request_unit.sv - directed self-checking bench for fetch_request_unit
module tb_fetch_request_unit;
  import fetch_request_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;

  fetch_request_unit_if bus ();

  fetch_request_unit #(
    .RESET_PC        (32'h8000_0000),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          flush_cnt = 0;
  logic        auto_resp;
  logic        pend_v;
  logic [31:0] pend_addr;
  logic [31:0] issued_q[$];
  logic [63:0] pushed_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pkt(input logic [31:0] pc, input logic [31:0] data);
    return {pc, data};
  endfunction

  // One cycle: inputs already set after a negedge; sample, cross the posedge, return at next negedge.
  task automatic tick();
    logic        iss;
    logic [31:0] addr;
    if (auto_resp) begin
      bus.mem_rvalid = pend_v;
      bus.mem_rdata  = ~pend_addr;
    end
    #1;
    iss  = bus.mem_req && bus.mem_ack;
    addr = bus.mem_addr;
    if (iss) issued_q.push_back(addr);
    if (bus.ib_push) pushed_q.push_back(bus.ib_data_in);
    if (bus.ib_flush) flush_cnt++;
    @(posedge clk);
    pend_v    = iss;
    pend_addr = addr;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0;
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.ib_pop = 1'b0;
    auto_resp = 1'b0; pend_v = 1'b0; pend_addr = '0;

    @(negedge clk);
    check("rst_mem_req", 64'(bus.mem_req), 64'(1'b0));
    check("rst_ib_push", 64'(bus.ib_push), 64'(1'b0));
    check("rst_ib_flush", 64'(bus.ib_flush), 64'(1'b0));
    check("rst_mem_addr", 64'(bus.mem_addr), 64'h8000_0000);
    rst = 1'b0;

    // 1: stream until the four buffer credits are used up
    fetch_en = 1'b1; bus.mem_ack = 1'b1; auto_resp = 1'b1;
    repeat (8) tick();
    check("t1_issue_cnt", 64'(issued_q.size()), 64'd4);
    check("t1_push_cnt", 64'(pushed_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      a = 32'h8000_0000 + 32'(4 * i);
      check($sformatf("t1_addr%0d", i), 64'(issued_q[i]), 64'(a));
      check($sformatf("t1_pkt%0d", i), pushed_q[i], pkt(a, ~a));
    end
    #1;
    check("t1_req_full", 64'(bus.mem_req), 64'(1'b0));

    // 2: one pop frees exactly one credit
    issued_q.delete(); pushed_q.delete();
    bus.ib_pop = 1'b1;
    tick();
    bus.ib_pop = 1'b0;
    #1;
    check("t2_req", 64'(bus.mem_req), 64'(1'b1));
    check("t2_addr", 64'(bus.mem_addr), 64'h8000_0010);
    repeat (5) tick();
    check("t2_issue_cnt", 64'(issued_q.size()), 64'd1);
    check("t2_push_cnt", 64'(pushed_q.size()), 64'd1);
    check("t2_pkt", pushed_q[0], pkt(32'h8000_0010, ~32'h8000_0010));
    check("t2_req_full", 64'(bus.mem_req), 64'(1'b0));

    // 3: redirect with two requests in flight
    issued_q.delete(); pushed_q.delete();
    auto_resp = 1'b0; bus.mem_rvalid = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    repeat (3) tick();
    check("t3_inflight", 64'(issued_q.size()), 64'd2);
    flush_cnt = 0;
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    #1;
    check("t3_flush", 64'(bus.ib_flush), 64'(1'b1));
    check("t3_req_blocked", 64'(bus.mem_req), 64'(1'b0));
    tick();
    redirect = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_1111;
    tick();
    bus.mem_rdata = 32'h2222_2222;
    tick();
    bus.mem_rvalid = 1'b0; auto_resp = 1'b1;
    tick();
    check("t3_flush_cnt", 64'(flush_cnt), 64'd1);
    check("t3_push_cnt", 64'(pushed_q.size()), 64'd1);
    check("t3_pkt", pushed_q[0], pkt(32'h0000_0100, ~32'h0000_0100));
    check("t3_addr", 64'(issued_q[2]), 64'h0000_0100);
    fetch_en = 1'b0;
    repeat (6) tick();

    // 4: redirect coinciding with a response and with mem_ack
    issued_q.delete(); pushed_q.delete();
    auto_resp = 1'b0; bus.mem_rvalid = 1'b0; fetch_en = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    repeat (2) tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0400;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("t4_push_blocked", 64'(bus.ib_push), 64'(1'b0));
    check("t4_req_blocked", 64'(bus.mem_req), 64'(1'b0));
    check("t4_flush", 64'(bus.ib_flush), 64'(1'b1));
    tick();
    redirect = 1'b0; bus.mem_rvalid = 1'b0;
    tick();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_5555;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = ~32'h0000_0400;
    tick();
    bus.mem_rvalid = 1'b0;
    check("t4_issue_cnt", 64'(issued_q.size()), 64'd3);
    check("t4_addr", 64'(issued_q[2]), 64'h0000_0400);
    check("t4_push_cnt", 64'(pushed_q.size()), 64'd1);
    check("t4_pkt", pushed_q[0], pkt(32'h0000_0400, ~32'h0000_0400));

    // 5: fetch disabled with one request in flight
    bus.mem_ack = 1'b1; fetch_en = 1'b0;
    tick();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = ~32'h0000_0404;
    #1;
    check("t5_req_off", 64'(bus.mem_req), 64'(1'b0));
    tick();
    bus.mem_rvalid = 1'b0;
    repeat (2) tick();
    check("t5_issue_cnt", 64'(issued_q.size()), 64'd4);
    check("t5_push_cnt", 64'(pushed_q.size()), 64'd2);
    check("t5_pkt", pushed_q[1], pkt(32'h0000_0404, ~32'h0000_0404));
    check("t5_req_idle", 64'(bus.mem_req), 64'(1'b0));

    // 6: asynchronous reset between clock edges
    auto_resp = 1'b1; fetch_en = 1'b1;
    repeat (2) tick();
    bus.mem_rvalid = pend_v; bus.mem_rdata = ~pend_addr;
    #1;
    check("t6_pre_req", 64'(bus.mem_req), 64'(1'b1));
    check("t6_pre_push", 64'(bus.ib_push), 64'(1'b1));
    #2 rst = 1'b1;
    #1;
    check("t6_rst_req", 64'(bus.mem_req), 64'(1'b0));
    check("t6_rst_push", 64'(bus.ib_push), 64'(1'b0));
    @(negedge clk);
    rst = 1'b0; bus.mem_rvalid = 1'b0; pend_v = 1'b0;
    issued_q.delete();
    for (int i = 0; i < 10 && issued_q.size() == 0; i++) tick();
    check("t6_reissue", 64'(issued_q.size() > 0), 64'(1'b1));
    check("t6_first_addr", (issued_q.size() > 0) ? 64'(issued_q[0]) : 64'hx, 64'h8000_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
